// File: rtl/mul_seq_pkg.sv
// mul_seq_pkg: shared state encoding and default width for the multiplier sequencer
package mul_seq_pkg;
    localparam int W_DEF = 16;
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD_A = 3'd1;
    localparam logic [2:0] S_LOAD_B = 3'd2;
    localparam logic [2:0] S_ACC    = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;
endpackage

// File: rtl/mul_seq_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector, first pending request at or after ptr
module rr_pick #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [IDW-1:0]  idx,
    output logic            valid
);
    always_comb begin
        idx   = '0;
        valid = |req;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % NREQ]) idx = IDW'((int'(ptr) + k) % NREQ);
        end
    end
endmodule

// File: rtl/mul_seq_arbiter.sv
// mul_seq_arbiter: round-robin sequencer sharing one repeated-addition multiplier datapath
// MUL_OPSWAP_EN: load max(a,b) into A and min(a,b) into the B counter to shorten accumulation
module mul_seq_arbiter
    import mul_seq_pkg::*;
#(
    parameter int W    = W_DEF,
    parameter int NREQ = 2,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ*W-1:0] op_a,
    input  logic [NREQ*W-1:0] op_b,
    output logic [NREQ-1:0] ack,
    output logic [W-1:0]    result,
    output logic            busy,
    output logic [IDW-1:0]  gnt_id,
    output logic            ld_a,
    output logic            ld_b,
    output logic            ld_p,
    output logic            clr_p,
    output logic            dec_b,
    output logic [W-1:0]    dp_bus,
    input  logic            eqz,
    input  logic [W-1:0]    dp_p
);
    logic [2:0]     state;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] pick;
    logic           pick_v;
    logic [W-1:0]   a_sel;
    logic [W-1:0]   b_sel;
    logic [W-1:0]   first_op;
    logic [W-1:0]   second_op;

    rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
        .req   (req),
        .ptr   (ptr),
        .idx   (pick),
        .valid (pick_v)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            gnt_id <= '0;
            ptr    <= '0;
            result <= '0;
        end else begin
            case (state)
                S_IDLE: if (pick_v) begin
                    gnt_id <= pick;
                    ptr    <= (pick == IDW'(NREQ - 1)) ? '0 : pick + IDW'(1);
                    state  <= S_LOAD_A;
                end
                S_LOAD_A: state <= S_LOAD_B;
                S_LOAD_B: state <= S_ACC;
                S_ACC: if (eqz) begin
                    result <= dp_p;
                    state  <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign a_sel = op_a[gnt_id*W +: W];
    assign b_sel = op_b[gnt_id*W +: W];

`ifdef MUL_OPSWAP_EN
    logic swap;
    assign swap      = b_sel > a_sel;
    assign first_op  = swap ? b_sel : a_sel;
    assign second_op = swap ? a_sel : b_sel;
`else
    assign first_op  = a_sel;
    assign second_op = b_sel;
`endif

    // Accumulate and count down together so B reaching zero marks the finished product
    assign ld_a   = state == S_LOAD_A;
    assign ld_b   = state == S_LOAD_B;
    assign clr_p  = state == S_LOAD_B;
    assign ld_p   = state == S_ACC && !eqz;
    assign dec_b  = state == S_ACC && !eqz;
    assign busy   = state != S_IDLE;
    assign dp_bus = ld_a ? first_op : ld_b ? second_op : '0;
    assign ack    = (state == S_DONE) ? NREQ'(1) << gnt_id : '0;
endmodule
